// File: rtl/booth_pkg.sv
// booth_pkg: shared constants and state encoding for the Booth
// partial-product bank (pp_bank) and its alignment helper (pp_align).
package booth_pkg;

    localparam int W_DEFAULT   = 8;
    localparam int NPP_DEFAULT = 4;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } bank_state_t;

endpackage

// File: rtl/pp_align.sv
// pp_align: places one signed Booth partial product at its weight 4^K
// inside a 2W-bit field (sign-extended, 2K zero LSBs, MSBs truncated).
// Ports:
//   i_pp      [W:0]    signed partial product, two's complement
//   o_aligned [2W-1:0] aligned partial product
module pp_align
    import booth_pkg::*;
#(
    parameter int W = W_DEFAULT,
    parameter int K = 0
)(
    input  logic [W:0]     i_pp,
    output logic [2*W-1:0] o_aligned
);

    logic [2*W-1:0] w_ext;

    // W-1 sign copies plus the W+1 bit product fill exactly 2W bits;
    // the left shift then drops the extra sign bits off the top.
    assign w_ext     = {{(W-1){i_pp[W]}}, i_pp};
    assign o_aligned = w_ext << (2 * K);

endmodule

// File: rtl/pp_bank.sv
// pp_bank: collects NPP aligned Booth partial products into a bank and
// presents the full bank with a valid/ready handshake (zero-bubble).
// Ports:
//   clk, clr        clock, asynchronous active-high reset
//   flush           synchronous abort: clears bank, back to slot 0
//   in_valid/ready  partial-product input handshake
//   pp_in [W:0]     signed partial product, neg_in its negate flag
//   idx             slot index for the next accepted partial product
//   out_valid/ready bank output handshake
//   pp_out          NPP slots of 2W bits, slot k at [(k+1)*2W-1:k*2W]
//   neg_out         bit k is the negate flag of slot k
module pp_bank
    import booth_pkg::*;
#(
    parameter int W    = W_DEFAULT,
    parameter int NPP  = NPP_DEFAULT,
    localparam int IW  = (NPP > 1) ? $clog2(NPP) : 1
)(
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [W:0]            pp_in,
    input  logic                  neg_in,
    output logic [IW-1:0]         idx,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NPP*2*W-1:0]    pp_out,
    output logic [NPP-1:0]        neg_out
);

    bank_state_t              r_state;
    bank_state_t              w_state_nxt;
    logic [IW-1:0]            r_idx;
    logic [IW-1:0]            w_idx_nxt;
    logic [NPP-1:0][2*W-1:0]  r_slot;
    logic [NPP-1:0][2*W-1:0]  w_aligned;
    logic [NPP-1:0]           r_neg;
    logic [NPP-1:0]           w_load;
    logic                     w_accept;
    logic                     w_last;

    for (genvar k = 0; k < NPP; k++) begin : g_align
        pp_align #(
            .W (W),
            .K (k)
        ) u_align (
            .i_pp      (pp_in),
            .o_aligned (w_aligned[k])
        );
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= FILL;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_accept    = 1'b0;
        w_last      = (r_idx == IW'(NPP - 1));

        unique case (r_state)
            FILL: in_ready = !flush;
            HOLD: begin
                // Accepting while the bank is taken keeps the stream gapless.
                in_ready  = out_ready && !flush;
                out_valid = 1'b1;
            end
            default: ;
        endcase

        w_accept = in_valid && in_ready;

        if (flush) begin
            w_state_nxt = FILL;
            w_idx_nxt   = '0;
        end else if (w_accept) begin
            // In HOLD idx is 0, so this also covers the hand-off accept.
            w_state_nxt = w_last ? HOLD : FILL;
            w_idx_nxt   = w_last ? '0 : r_idx + 1'b1;
        end else if (r_state == HOLD && out_ready) begin
            w_state_nxt = FILL;
            w_idx_nxt   = '0;
        end
    end

    always_comb begin
        w_load = '0;
        for (int i = 0; i < NPP; i++) begin
            w_load[i] = w_accept && (r_idx == IW'(i));
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_slot <= '0;
            r_neg  <= '0;
        end else if (flush) begin
            r_slot <= '0;
            r_neg  <= '0;
        end else begin
            for (int i = 0; i < NPP; i++) begin
                if (w_load[i]) begin
                    r_slot[i] <= w_aligned[i];
                    r_neg[i]  <= neg_in;
                end
            end
        end
    end

    assign idx     = r_idx;
    assign pp_out  = r_slot;
    assign neg_out = r_neg;

endmodule
